// File: rtl/washing_machine_ctrl_multi.sv
// Washing machine sequencer: fill/wash/drain with N rinse passes, spin, fill timeout, abort and door faults.
// Optional pause (WASHER_PAUSE_EN): holds timed/fill states, drops motor and fill valve.
module washing_machine_ctrl_multi #(
  parameter int WASH_CYCLES  = 16,
  parameter int RINSE_CYCLES = 8,
  parameter int SPIN_CYCLES  = 8,
  parameter int RINSE_COUNT  = 2,
  parameter int FILL_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_close,
  input  logic       start,
  input  logic       filled,
  input  logic       detergent_added,
  input  logic       drained,
  input  logic       abort,
  input  logic       pause,
  output logic       door_lock,
  output logic       motor_on,
  output logic       fill_value_on,
  output logic       drain_value_on,
  output logic       soap_wash,
  output logic       water_wash,
  output logic       done,
  output logic       error,
  output logic [3:0] state,
  output logic [3:0] rinse_left
);

  localparam int MAX_WR  = (WASH_CYCLES > RINSE_CYCLES) ? WASH_CYCLES : RINSE_CYCLES;
  localparam int MAX_SF  = (SPIN_CYCLES > FILL_TIMEOUT) ? SPIN_CYCLES : FILL_TIMEOUT;
  localparam int MAX_ALL = (MAX_WR > MAX_SF) ? MAX_WR : MAX_SF;
  localparam int TW      = $clog2(MAX_ALL + 1);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_FILL_SOAP   = 4'd1,
    S_WASH_SOAP   = 4'd2,
    S_DRAIN_SOAP  = 4'd3,
    S_FILL_RINSE  = 4'd4,
    S_WASH_RINSE  = 4'd5,
    S_DRAIN_RINSE = 4'd6,
    S_SPIN        = 4'd7,
    S_DONE        = 4'd8,
    S_FAULT       = 4'd9
  } state_e;

  typedef struct packed {
    logic lock;
    logic motor;
    logic fill;
    logic drain;
    logic soap;
    logic water;
    logic done;
    logic err;
  } act_t;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    rinse_q, rinse_d;
  act_t          act_q, act_d;
  logic          fault_req;
  logic          hold;
  logic          tmr_zero;
  logic [3:0]    rinse_dec;

  assign fault_req = abort || !door_close;
  assign tmr_zero  = (timer_q == '0);
  assign rinse_dec = (rinse_q == 4'd0) ? 4'd0 : rinse_q - 4'd1;

`ifdef WASHER_PAUSE_EN
  assign hold = pause && !fault_req &&
                (state_q inside {S_FILL_SOAP, S_WASH_SOAP, S_FILL_RINSE, S_WASH_RINSE, S_SPIN});
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rinse_d = rinse_q;
    case (state_q)
      S_IDLE: begin
        if (start && door_close) begin
          state_d = S_FILL_SOAP;
          rinse_d = 4'(RINSE_COUNT);
          timer_d = TW'(FILL_TIMEOUT - 1);
        end
      end
      S_DONE:  if (!start) state_d = S_IDLE;
      S_FAULT: if (drained && !start) state_d = S_IDLE;
      S_FILL_SOAP, S_WASH_SOAP, S_DRAIN_SOAP, S_FILL_RINSE,
      S_WASH_RINSE, S_DRAIN_RINSE, S_SPIN: begin
        if (fault_req) begin
          state_d = S_FAULT;
        end else if (!hold) begin
          case (state_q)
            S_FILL_SOAP: begin
              if (filled && detergent_added) begin
                state_d = S_WASH_SOAP;
                timer_d = TW'(WASH_CYCLES - 1);
              end else if (tmr_zero) state_d = S_FAULT;
              else timer_d = timer_q - TW'(1);
            end
            S_WASH_SOAP: begin
              if (tmr_zero) state_d = S_DRAIN_SOAP;
              else timer_d = timer_q - TW'(1);
            end
            S_DRAIN_SOAP: begin
              if (drained) begin
                if (rinse_q != 4'd0) begin
                  state_d = S_FILL_RINSE;
                  timer_d = TW'(FILL_TIMEOUT - 1);
                end else begin
                  state_d = S_SPIN;
                  timer_d = TW'(SPIN_CYCLES - 1);
                end
              end
            end
            S_FILL_RINSE: begin
              if (filled) begin
                state_d = S_WASH_RINSE;
                timer_d = TW'(RINSE_CYCLES - 1);
              end else if (tmr_zero) state_d = S_FAULT;
              else timer_d = timer_q - TW'(1);
            end
            S_WASH_RINSE: begin
              if (tmr_zero) state_d = S_DRAIN_RINSE;
              else timer_d = timer_q - TW'(1);
            end
            S_DRAIN_RINSE: begin
              if (drained) begin
                rinse_d = rinse_dec;
                if (rinse_dec != 4'd0) begin
                  state_d = S_FILL_RINSE;
                  timer_d = TW'(FILL_TIMEOUT - 1);
                end else begin
                  state_d = S_SPIN;
                  timer_d = TW'(SPIN_CYCLES - 1);
                end
              end
            end
            S_SPIN: begin
              if (tmr_zero) state_d = S_DONE;
              else timer_d = timer_q - TW'(1);
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_FAULT;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy matches the state register.
  always_comb begin
    act_d = '0;
    case (state_d)
      S_FILL_SOAP, S_FILL_RINSE: begin
        act_d.lock = 1'b1;
        act_d.fill = !hold;
      end
      S_WASH_SOAP: begin
        act_d.lock  = 1'b1;
        act_d.motor = !hold;
        act_d.soap  = 1'b1;
      end
      S_WASH_RINSE: begin
        act_d.lock  = 1'b1;
        act_d.motor = !hold;
        act_d.water = 1'b1;
      end
      S_DRAIN_SOAP, S_DRAIN_RINSE: begin
        act_d.lock  = 1'b1;
        act_d.drain = 1'b1;
      end
      S_SPIN: begin
        act_d.lock  = 1'b1;
        act_d.motor = !hold;
        act_d.drain = 1'b1;
      end
      S_DONE:  act_d.done = 1'b1;
      S_FAULT: begin
        act_d.err   = 1'b1;
        act_d.lock  = !drained;
        act_d.drain = !drained;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rinse_q <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rinse_q <= rinse_d;
      act_q   <= act_d;
    end
  end

  assign door_lock      = act_q.lock;
  assign motor_on       = act_q.motor;
  assign fill_value_on  = act_q.fill;
  assign drain_value_on = act_q.drain;
  assign soap_wash      = act_q.soap;
  assign water_wash     = act_q.water;
  assign done           = act_q.done;
  assign error          = act_q.err;
  assign state          = state_q;
  assign rinse_left     = rinse_q;

endmodule

// File: tb/tb_washing_machine_ctrl_multi.sv
// Directed bench: u0 runs two rinse passes (fill timeout 5), u1 has rinse count 0.
module tb_washing_machine_ctrl_multi;

  localparam logic [7:0] O_IDLE  = 8'h00;
  localparam logic [7:0] O_FILL  = 8'hA0;
  localparam logic [7:0] O_WASHS = 8'hC8;
  localparam logic [7:0] O_DRAIN = 8'h90;
  localparam logic [7:0] O_WASHR = 8'hC4;
  localparam logic [7:0] O_SPIN  = 8'hD0;
  localparam logic [7:0] O_DONE  = 8'h02;
  localparam logic [7:0] O_FLTL  = 8'h91;
  localparam logic [7:0] O_FLTD  = 8'h01;

  logic clk = 1'b0, reset = 1'b1;
  logic door_close = 0, start = 0, filled = 0, detergent_added = 0, drained = 0, abort = 0, pause = 0;
  logic a_lock, a_motor, a_fill, a_drain, a_soap, a_water, a_done, a_err;
  logic b_lock, b_motor, b_fill, b_drain, b_soap, b_water, b_done, b_err;
  logic [3:0] a_state, a_rinse, b_state, b_rinse;
  int n_cmp = 0, n_err = 0;
  int cnt;

  always #5 clk = ~clk;

  washing_machine_ctrl_multi #(.WASH_CYCLES(4), .RINSE_CYCLES(3), .SPIN_CYCLES(2),
    .RINSE_COUNT(2), .FILL_TIMEOUT(5)) u0 (
    .clk(clk), .reset(reset), .door_close(door_close), .start(start), .filled(filled),
    .detergent_added(detergent_added), .drained(drained), .abort(abort), .pause(pause),
    .door_lock(a_lock), .motor_on(a_motor), .fill_value_on(a_fill), .drain_value_on(a_drain),
    .soap_wash(a_soap), .water_wash(a_water), .done(a_done), .error(a_err),
    .state(a_state), .rinse_left(a_rinse));

  washing_machine_ctrl_multi #(.WASH_CYCLES(4), .RINSE_CYCLES(3), .SPIN_CYCLES(2),
    .RINSE_COUNT(0), .FILL_TIMEOUT(5)) u1 (
    .clk(clk), .reset(reset), .door_close(door_close), .start(start), .filled(filled),
    .detergent_added(detergent_added), .drained(drained), .abort(abort), .pause(pause),
    .door_lock(b_lock), .motor_on(b_motor), .fill_value_on(b_fill), .drain_value_on(b_drain),
    .soap_wash(b_soap), .water_wash(b_water), .done(b_done), .error(b_err),
    .state(b_state), .rinse_left(b_rinse));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] st, input logic [7:0] o);
    chk({tag, ".state"}, 32'(a_state), 32'(st));
    chk({tag, ".outs"}, 32'({a_lock, a_motor, a_fill, a_drain, a_soap, a_water, a_done, a_err}), 32'(o));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] st, input logic [7:0] o);
    chk({tag, ".state"}, 32'(b_state), 32'(st));
    chk({tag, ".outs"}, 32'({b_lock, b_motor, b_fill, b_drain, b_soap, b_water, b_done, b_err}), 32'(o));
  endtask

  task automatic do_reset;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_a(input logic [3:0] s, input int bound, input string tag);
    int k = 0;
    while (a_state !== s && k < bound) begin
      tick();
      k++;
    end
    chk(tag, 32'(a_state), 32'(s));
  endtask

  task automatic idle_inputs;
    start = 0; filled = 0; detergent_added = 0; drained = 0; abort = 0; pause = 0;
  endtask

  initial begin
    #1 reset = 1'b0;
    tick();
    chk_a("rst_a", 4'd0, O_IDLE);
    chk_b("rst_b", 4'd0, O_IDLE);
    chk("rst_rinse", 32'(a_rinse), 32'd0);
    reset = 1'b1;

    // Normal run with two rinse passes
    door_close = 1; start = 1;
    tick(); chk_a("fill_soap", 4'd1, O_FILL); chk("rinse_load", 32'(a_rinse), 32'd2);
    filled = 1; detergent_added = 1;
    tick(); chk_a("wash_soap0", 4'd2, O_WASHS);
    filled = 0; detergent_added = 0;
    repeat (3) begin tick(); chk_a("wash_soap", 4'd2, O_WASHS); end
    tick(); chk_a("drain_soap", 4'd3, O_DRAIN);
    drained = 1;
    tick(); chk_a("fill_rinse", 4'd4, O_FILL); chk("rinse_2", 32'(a_rinse), 32'd2);
    drained = 0;
    for (int p = 0; p < 2; p++) begin
      filled = 1;
      tick(); chk_a("wash_rinse0", 4'd5, O_WASHR);
      filled = 0;
      repeat (2) begin tick(); chk_a("wash_rinse", 4'd5, O_WASHR); end
      tick(); chk_a("drain_rinse", 4'd6, O_DRAIN);
      drained = 1;
      tick();
      if (p == 0) chk_a("refill_rinse", 4'd4, O_FILL);
      else chk_a("spin0", 4'd7, O_SPIN);
      chk("rinse_dec", 32'(a_rinse), 32'(1 - p));
      drained = 0;
    end
    tick(); chk_a("spin1", 4'd7, O_SPIN);
    tick(); chk_a("done", 4'd8, O_DONE);
    tick(); chk_a("done_hold", 4'd8, O_DONE);
    start = 0;
    tick(); chk_a("back_idle", 4'd0, O_IDLE);

    // Rinse count 0 on u1: sensors held high
    do_reset();
    start = 1; filled = 1; detergent_added = 1; drained = 1;
    tick(); chk_b("r0_fill", 4'd1, O_FILL);
    tick(); chk_b("r0_wash0", 4'd2, O_WASHS);
    repeat (3) begin tick(); chk_b("r0_wash", 4'd2, O_WASHS); end
    tick(); chk_b("r0_drain", 4'd3, O_DRAIN);
    tick(); chk_b("r0_spin0", 4'd7, O_SPIN);
    tick(); chk_b("r0_spin1", 4'd7, O_SPIN);
    tick(); chk_b("r0_done", 4'd8, O_DONE);
    idle_inputs();
    tick(); chk_b("r0_idle", 4'd0, O_IDLE);

    // Fill timeout
    do_reset();
    start = 1;
    tick(); chk_a("to_fill0", 4'd1, O_FILL);
    repeat (4) begin tick(); chk_a("to_fill", 4'd1, O_FILL); end
    tick(); chk_a("to_fault", 4'd9, O_FLTL);
    tick(); chk_a("to_fault_hold", 4'd9, O_FLTL);
    drained = 1;
    tick(); chk_a("to_drained", 4'd9, O_FLTD);
    start = 0;
    tick(); chk_a("to_idle", 4'd0, O_IDLE);
    drained = 0;

    // Abort and door open together during soap wash
    do_reset();
    start = 1;
    tick(); chk_a("ab_fill", 4'd1, O_FILL);
    filled = 1; detergent_added = 1;
    tick(); chk_a("ab_wash", 4'd2, O_WASHS);
    filled = 0; detergent_added = 0; abort = 1; door_close = 0;
    tick(); chk_a("ab_fault", 4'd9, O_FLTL);
    abort = 0; door_close = 1; start = 0; drained = 1;
    tick(); chk_a("ab_idle", 4'd0, O_IDLE);
    idle_inputs();

    // Async reset in the middle of spin
    do_reset();
    start = 1; filled = 1; detergent_added = 1; drained = 1;
    wait_a(4'd7, 40, "reach_spin");
    #2 reset = 1'b0;
    #1 chk_a("async_rst", 4'd0, O_IDLE);
    chk("async_rinse", 32'(a_rinse), 32'd0);
    reset = 1'b1;
    tick(); chk_a("restart", 4'd1, O_FILL);

    // Pause during rinse wash
    idle_inputs();
    do_reset();
    start = 1; filled = 1; detergent_added = 1; drained = 1;
    wait_a(4'd5, 40, "reach_rinse");
    cnt = a_water ? 1 : 0;
    pause = 1;
    tick();
`ifdef WASHER_PAUSE_EN
    chk("pause_motor", 32'(a_motor), 32'd0);
`else
    chk("pause_motor", 32'(a_motor), 32'd1);
`endif
    chk("pause_lock", 32'(a_lock), 32'd1);
    if (a_water) cnt++;
    repeat (2) begin tick(); if (a_water) cnt++; end
    pause = 0;
    for (int k = 0; k < 20; k++) begin
      if (!a_water) break;
      tick();
      if (a_water) cnt++;
    end
`ifdef WASHER_PAUSE_EN
    chk("water_time", 32'(cnt), 32'd6);
`else
    chk("water_time", 32'(cnt), 32'd3);
`endif
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
